phase_timer: RTL and testbench
==============================

Name: phase_timer

Overview:
- Parametrised, programmable countdown timer for the intersection controller. It replaces the fixed 1 s / 10 s cascade and the rate selector with a single block.
- A prescaler produces a base tick at a selectable rate. A loadable down-counter counts those ticks and signals expiry with a one-cycle pulse.
- Outputs are the remaining count in binary and as two BCD digits for the 7-segment decoders.
- The traffic-light FSM instantiates one per light phase (green/amber/red durations).

Parameters:
- TICK_DIV, 50000000: CLOCK_50 cycles per base tick (1 s at 50 MHz).
- CNT_W, 8: width of the countdown value.
- PS_W, 28: prescaler width. Must hold 4*TICK_DIV-1; integrator checks at instantiation.

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  load load_val into count (one-cycle strobe).
- load_val  in  CNT_W  count value to load.
- start  in  1  begin/resume counting.
- pause  in  1  hold count and prescaler.
- clear  in  1  abort: count=0, go to IDLE.
- rate_sel  in  2  tick period: 00=1 cycle, 01=TICK_DIV, 10=2*TICK_DIV, 11=4*TICK_DIV.
- tick  out  1  one-cycle pulse at each base tick while RUN.
- remaining  out  CNT_W  current count.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  one-cycle expiry pulse.
- bcd_tens  out  4  tens digit of remaining.
- bcd_ones  out  4  ones digit of remaining.

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE; prescaler=0; count=0; reload register=0.
  - tick=0, done=0, busy=0, remaining=0, bcd_tens=0, bcd_ones=0.
- States: IDLE, RUN, PAUSE, DONE. busy is decoded from the state register.
- Control priority on one edge: clear > load > start > pause.
  - clear: count=0, prescaler=0, state=IDLE, no done pulse.
  - load (any state): count=load_val, reload reg=load_val, prescaler=0, state=IDLE. start on the same edge is ignored; start must follow on a later cycle.
  - start in IDLE or PAUSE: count!=0 -> RUN; count==0 -> DONE with done=1 on the next cycle.
  - start in RUN or DONE: ignored.
  - pause in RUN -> PAUSE. Prescaler and count are frozen; the next start resumes from the frozen prescaler value.
- Prescaler:
  - Counts only in RUN. Period P = 1, TICK_DIV, 2*TICK_DIV or 4*TICK_DIV per rate_sel.
  - When prescaler==P-1: prescaler wraps to 0, tick is high for that cycle (combinational from the state and prescaler), and count decrements on that edge.
  - A rate_sel change is registered; on the change edge prescaler resets to 0, so the next tick is a full new period later.
- Expiry:
  - On the tick edge with count==1: count becomes 0 and state becomes DONE.
  - done is registered: high exactly one cycle, the cycle after that edge.
  - DONE holds until load, clear or reset. remaining=0 while in DONE.
- Latency:
  - N = loaded count, P = period.
  - RUN entered on edge E; done is high during cycle E+N*P+1 after edge E.
  - With rate_sel=00, N=3: ticks on the 3 cycles after start, done on the 4th.
- BCD:
  - Combinational from count (double-dabble or divide by 10).
  - remaining>99 -> both digits 4'h9 (saturate). Display shows 99; remaining carries the true value.
- No wrap: count never decrements below 0.

Optional Feature:
- Macro PHASE_TIMER_AUTO_RELOAD_EN.
- Defined: on expiry the block reloads count from the reload register, stays in RUN and keeps the prescaler free-running. done still pulses once per expiry, so it is periodic with period N*P. A reload value of 0 goes to DONE instead (no infinite zero-period loop).
- Undefined: expiry goes to DONE and holds, as described above.

Test Plan:
- Bench uses TICK_DIV=4.
- Reset mid-RUN with count=5: one cycle after the reset edge, remaining=0, busy=0, done=0, tick=0. The state stays IDLE through later start pulses until a load arrives.
- load_val=3, start, rate_sel=01: ticks at cycles 4, 8, 12 after the start edge. remaining steps 3,2,1,0. done high only at cycle 13. busy falls with the DONE transition.
- load_val=5, start, pause after 2 ticks held 10 cycles, then start: remaining stays 3 throughout the pause and no tick occurs. The resumed run gives done exactly 12 cycles later than an unpaused run.
- load_val=0, then start: done high the cycle after the start edge, with no tick. clear together with load and start on one edge: IDLE, remaining=0.
- load_val=123: bcd_tens=9, bcd_ones=9, remaining=123. load_val=47: bcd_tens=4, bcd_ones=7. After one tick with rate_sel=00: 4/6.
- With PHASE_TIMER_AUTO_RELOAD_EN, load_val=2, rate_sel=00, start: done pulses every 2 cycles and remaining cycles 2,1,2,1. busy stays high.

Source files
------------

// File: rtl/phase_timer_if.sv
// Control/status bundle between the intersection FSM (master) and one phase_timer (slave).
interface phase_timer_if #(
    parameter int CNT_W = 8
);
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             start;
    logic             pause;
    logic             clear;
    logic [1:0]       rate_sel;
    logic             tick;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic             done;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;

    modport master (
        output load, load_val, start, pause, clear, rate_sel,
        input  tick, remaining, busy, done, bcd_tens, bcd_ones
    );

    modport slave (
        input  load, load_val, start, pause, clear, rate_sel,
        output tick, remaining, busy, done, bcd_tens, bcd_ones
    );
endinterface

// File: rtl/phase_timer.sv
// Programmable countdown timer with prescaler, expiry pulse and saturating BCD readout.
// Optional macro PHASE_TIMER_AUTO_RELOAD_EN: periodic reload from the reload register on expiry.
module phase_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 8,
    parameter int PS_W     = 28
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    phase_timer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam logic [PS_W-1:0] PS_MAX_1 = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0] PS_MAX_2 = PS_W'(2 * TICK_DIV - 1);
    localparam logic [PS_W-1:0] PS_MAX_4 = PS_W'(4 * TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [PS_W-1:0]  ps_q, ps_d, ps_max;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic [1:0]       rate_q;
    logic             done_q, done_d;
    logic             armed_q, armed_d;
    logic             tick;
    logic [31:0]      cnt_ext;

    always_comb begin
        case (rate_q)
            2'b00:   ps_max = '0;
            2'b01:   ps_max = PS_MAX_1;
            2'b10:   ps_max = PS_MAX_2;
            default: ps_max = PS_MAX_4;
        endcase
    end

    assign tick = (state_q == S_RUN) && (ps_q == ps_max);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        state_d  = state_q;
        ps_d     = ps_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        armed_d  = armed_q;
        done_d   = 1'b0;

        if (bus.clear) begin
            cnt_d   = '0;
            ps_d    = '0;
            state_d = S_IDLE;
        end else if (bus.load) begin
            cnt_d    = bus.load_val;
            reload_d = bus.load_val;
            ps_d     = '0;
            armed_d  = 1'b1;
            state_d  = S_IDLE;
        end else if (bus.start && (state_q == S_PAUSE || (state_q == S_IDLE && armed_q))) begin
            // After reset nothing has been loaded yet, so start is ignored until the first load.
            if (cnt_q != '0) begin
                state_d = S_RUN;
            end else begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end else if (bus.pause && state_q == S_RUN) begin
            state_d = S_PAUSE;
        end else if (state_q == S_RUN) begin
            ps_d = tick ? '0 : ps_q + 1'b1;
            if (tick) begin
                if (cnt_q == CNT_W'(1)) begin
                    done_d = 1'b1;
`ifdef PHASE_TIMER_AUTO_RELOAD_EN
                    if (reload_q != '0) begin
                        cnt_d = reload_q;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end
`else
                    cnt_d   = '0;
                    state_d = S_DONE;
`endif
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end

        // A new rate restarts the period so the next tick is a full new period away.
        if (bus.rate_sel != rate_q) begin
            ps_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q  <= S_IDLE;
            ps_q     <= '0;
            cnt_q    <= '0;
            reload_q <= '0;
            rate_q   <= 2'b00;
            done_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ps_q     <= ps_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            rate_q   <= bus.rate_sel;
            done_q   <= done_d;
            armed_q  <= armed_d;
        end
    end

    assign cnt_ext = 32'(cnt_q);

    always_comb begin
        if (cnt_ext > 32'd99) begin
            bus.bcd_tens = 4'h9;
            bus.bcd_ones = 4'h9;
        end else begin
            bus.bcd_tens = 4'(cnt_ext / 32'd10);
            bus.bcd_ones = 4'(cnt_ext % 32'd10);
        end
    end

    assign bus.tick      = tick;
    assign bus.remaining = cnt_q;
    assign bus.busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: vector table plus multi-cycle run/pause/reset/reload sequences.
module tb_phase_timer;
    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 8;
    localparam int PS_W     = 5;
`ifdef PHASE_TIMER_AUTO_RELOAD_EN
    localparam int AUTO = 1;
`else
    localparam int AUTO = 0;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    phase_timer_if #(.CNT_W(CNT_W)) bus ();

    phase_timer #(
        .TICK_DIV(TICK_DIV),
        .CNT_W   (CNT_W),
        .PS_W    (PS_W)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic [7:0] val;
        logic       start;
        logic       pause;
        logic       clear;
        logic [7:0] rem;
        logic       busy;
        logic       done;
        logic       tick;
        logic [3:0] tens;
        logic [3:0] ones;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.load     = 1'b0;
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic check_all(input string tag, input int rem, input int busy, input int done,
                             input int tick, input int tens, input int ones);
        check({tag, ".rem"},  32'(bus.remaining), 32'(rem));
        check({tag, ".busy"}, 32'(bus.busy),      32'(busy));
        check({tag, ".done"}, 32'(bus.done),      32'(done));
        check({tag, ".tick"}, 32'(bus.tick),      32'(tick));
        check({tag, ".tens"}, 32'(bus.bcd_tens),  32'(tens));
        check({tag, ".ones"}, 32'(bus.bcd_ones),  32'(ones));
    endtask

    initial begin
        int done_cycle;
        n_tests = 0;
        n_fail  = 0;

        //              load  val     start pause clear rem     busy  done  tick  tens  ones
        vecs[0]  = '{1'b1, 8'd123, 1'b0, 1'b0, 1'b0, 8'd123, 1'b0, 1'b0, 1'b0, 4'd9, 4'd9};
        vecs[1]  = '{1'b1, 8'd47,  1'b0, 1'b0, 1'b0, 8'd47,  1'b0, 1'b0, 1'b0, 4'd4, 4'd7};
        vecs[2]  = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd47,  1'b1, 1'b0, 1'b1, 4'd4, 4'd7};
        vecs[3]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd46,  1'b1, 1'b0, 1'b1, 4'd4, 4'd6};
        vecs[4]  = '{1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 8'd46,  1'b1, 1'b0, 1'b0, 4'd4, 4'd6};
        vecs[5]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd46,  1'b1, 1'b0, 1'b0, 4'd4, 4'd6};
        vecs[6]  = '{1'b1, 8'd9,   1'b1, 1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[7]  = '{1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[8]  = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
        vecs[9]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[10] = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[11] = '{1'b1, 8'd99,  1'b0, 1'b0, 1'b0, 8'd99,  1'b0, 1'b0, 1'b0, 4'd9, 4'd9};
        vecs[12] = '{1'b1, 8'd100, 1'b0, 1'b0, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 4'd9, 4'd9};
        vecs[13] = '{1'b1, 8'd10,  1'b0, 1'b0, 1'b0, 8'd10,  1'b0, 1'b0, 1'b0, 4'd1, 4'd0};

        reset        = 1'b1;
        bus.load_val = '0;
        bus.rate_sel = 2'b00;
        quiet();
        step();
        step();
        check_all("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            bus.load     = vecs[i].load;
            bus.load_val = vecs[i].val;
            bus.start    = vecs[i].start;
            bus.pause    = vecs[i].pause;
            bus.clear    = vecs[i].clear;
            step();
            quiet();
            check_all($sformatf("vec%0d", i), int'(vecs[i].rem), int'(vecs[i].busy),
                      int'(vecs[i].done), int'(vecs[i].tick), int'(vecs[i].tens),
                      int'(vecs[i].ones));
        end

        // N=3 at rate 01 (P=4): ticks at 4, 8, 12, done at 13.
        bus.rate_sel = 2'b01;
        step();
        bus.load = 1'b1; bus.load_val = 8'd3;
        step();
        quiet();
        bus.start = 1'b1;
        step();
        quiet();
        for (int k = 1; k <= 15; k++) begin
            check($sformatf("run3.tick@%0d", k), 32'(bus.tick), 32'((k % 4 == 0) && (k <= 12)));
            check($sformatf("run3.done@%0d", k), 32'(bus.done), 32'(k == 13));
            check($sformatf("run3.rem@%0d", k), 32'(bus.remaining),
                  (k <= 4) ? 3 : (k <= 8) ? 2 : (k <= 12) ? 1 : (AUTO != 0 ? 3 : 0));
            check($sformatf("run3.busy@%0d", k), 32'(bus.busy), (k <= 12) ? 1 : AUTO);
            step();
        end

        // N=5, pause in cycle 9 held through 18, resume with start in cycle 20.
        bus.load = 1'b1; bus.load_val = 8'd5;
        step();
        quiet();
        bus.start = 1'b1;
        step();
        quiet();
        done_cycle = 0;
        for (int k = 1; k <= 33; k++) begin
            check($sformatf("pause.tick@%0d", k), 32'(bus.tick),
                  32'(k == 4 || k == 8 || k == 24 || k == 28 || k == 32));
            check($sformatf("pause.done@%0d", k), 32'(bus.done), 32'(k == 33));
            check($sformatf("pause.rem@%0d", k), 32'(bus.remaining),
                  (k <= 4) ? 5 : (k <= 8) ? 4 : (k <= 24) ? 3 : (k <= 28) ? 2 :
                  (k <= 32) ? 1 : (AUTO != 0 ? 5 : 0));
            check($sformatf("pause.busy@%0d", k), 32'(bus.busy), (k <= 32) ? 1 : AUTO);
            if (bus.done === 1'b1 && done_cycle == 0) done_cycle = k;
            bus.pause = (k >= 9 && k <= 18);
            bus.start = (k == 20);
            step();
            quiet();
        end
        check("pause.delay", 32'(done_cycle - 21), 32'd12);

        // Reset while running with count=5, then start pulses must not leave IDLE.
        bus.load = 1'b1; bus.load_val = 8'd5;
        step();
        quiet();
        bus.start = 1'b1;
        step();
        quiet();
        step();
        step();
        check("prereset.busy", 32'(bus.busy), 32'd1);
        reset = 1'b1; bus.start = 1'b1;
        step();
        reset = 1'b0;
        quiet();
        check_all("midreset", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            bus.start = 1'b1;
            step();
            quiet();
            step();
            check($sformatf("postreset.busy%0d", i), 32'(bus.busy), 32'd0);
            check($sformatf("postreset.done%0d", i), 32'(bus.done), 32'd0);
            check($sformatf("postreset.rem%0d", i), 32'(bus.remaining), 32'd0);
        end

`ifdef PHASE_TIMER_AUTO_RELOAD_EN
        bus.rate_sel = 2'b00;
        step();
        bus.load = 1'b1; bus.load_val = 8'd2;
        step();
        quiet();
        bus.start = 1'b1;
        step();
        quiet();
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("auto.rem@%0d", k), 32'(bus.remaining), (k % 2 == 1) ? 2 : 1);
            check($sformatf("auto.done@%0d", k), 32'(bus.done), 32'((k >= 3) && (k % 2 == 1)));
            check($sformatf("auto.busy@%0d", k), 32'(bus.busy), 32'd1);
            step();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
